// File: rtl/imem_boot_loader.sv
// Boot loader: streams an image into instruction-memory port B from address 0, waits for the
// fetch pipeline to settle, then releases CPU reset. Optional macro: BOOT_CHECKSUM_EN.
module imem_boot_loader #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int RELEASE_DLY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              s_valid_i,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_last_i,
  output logic              s_ready_o,
  output logic [3:0]        im_web_o,
  output logic [ADDR_W-1:0] im_addrb_o,
  output logic [DATA_W-1:0] im_dinb_o,
  output logic              cpu_rst_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   word_cnt_o
);

  localparam int DLY_W = (RELEASE_DLY > 1) ? $clog2(RELEASE_DLY) : 1;
  localparam logic [ADDR_W:0] CNT_MAX = {1'b0, {ADDR_W{1'b1}}};

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, RUN, ERR} state_t;

  state_t              state_reg, state_next;
  logic [DLY_W-1:0]    dly_reg, dly_next;
  logic [ADDR_W:0]     word_cnt_reg;
  logic                s_ready_reg, cpu_rst_reg, busy_reg, done_reg, err_reg;
  logic [3:0]          web_reg;
  logic [ADDR_W-1:0]   addrb_reg;
  logic [DATA_W-1:0]   dinb_reg;

  logic accept, do_write, overflow, start_load;

  assign accept     = s_valid_i & s_ready_reg;
  assign overflow   = accept & ~s_last_i & (word_cnt_reg == CNT_MAX);
  assign start_load = start_i & ((state_reg == IDLE) | (state_reg == RUN) | (state_reg == ERR));

`ifdef BOOT_CHECKSUM_EN
  logic [DATA_W-1:0] sum_reg;
  logic              sum_ok;

  // The checksum beat itself is never written nor summed.
  assign do_write = accept & ~s_last_i;
  assign sum_ok   = (sum_reg == s_data_i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_reg <= '0;
    end else if (start_load) begin
      sum_reg <= '0;
    end else if (do_write) begin
      sum_reg <= sum_reg + s_data_i;
    end
  end
`else
  assign do_write = accept;
`endif

  always_comb begin
    state_next = state_reg;
    dly_next   = dly_reg;
    case (state_reg)
      IDLE, RUN, ERR: begin
        if (start_i) state_next = LOAD;
      end
      LOAD: begin
        if (accept & s_last_i) begin
`ifdef BOOT_CHECKSUM_EN
          state_next = sum_ok ? DRAIN : ERR;
`else
          state_next = DRAIN;
`endif
          // Counting down to zero inclusive gives RELEASE_DLY cycles in DRAIN.
          dly_next = DLY_W'(RELEASE_DLY - 1);
        end else if (overflow) begin
          state_next = ERR;
        end
      end
      DRAIN: begin
        if (dly_reg == '0) state_next = RUN;
        else               dly_next   = dly_reg - 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so every output is a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      dly_reg      <= '0;
      word_cnt_reg <= '0;
      s_ready_reg  <= 1'b0;
      cpu_rst_reg  <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      web_reg      <= 4'h0;
      addrb_reg    <= '0;
      dinb_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      dly_reg     <= dly_next;
      s_ready_reg <= (state_next == LOAD);
      cpu_rst_reg <= (state_next != RUN);
      busy_reg    <= (state_next == LOAD) || (state_next == DRAIN);
      done_reg    <= (state_next == RUN);
      err_reg     <= (state_next == ERR);
      web_reg     <= do_write ? 4'hF : 4'h0;
      if (do_write) begin
        addrb_reg    <= word_cnt_reg[ADDR_W-1:0];
        dinb_reg     <= s_data_i;
        word_cnt_reg <= word_cnt_reg + 1'b1;
      end else if (start_load) begin
        word_cnt_reg <= '0;
      end
    end
  end

  assign s_ready_o  = s_ready_reg;
  assign im_web_o   = web_reg;
  assign im_addrb_o = addrb_reg;
  assign im_dinb_o  = dinb_reg;
  assign cpu_rst_o  = cpu_rst_reg;
  assign busy_o     = busy_reg;
  assign done_o     = done_reg;
  assign err_o      = err_reg;
  assign word_cnt_o = word_cnt_reg;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized bench for imem_boot_loader against an image-level reference model (small ADDR_W).
module tb_imem_boot_loader;

  localparam int ADDR_W      = 4;
  localparam int DATA_W      = 32;
  localparam int RELEASE_DLY = 3;
  localparam int DEPTH       = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_i = 1'b0;
  logic              s_valid_i = 1'b0;
  logic [DATA_W-1:0] s_data_i = '0;
  logic              s_last_i = 1'b0;
  logic              s_ready_o;
  logic [3:0]        im_web_o;
  logic [ADDR_W-1:0] im_addrb_o;
  logic [DATA_W-1:0] im_dinb_o;
  logic              cpu_rst_o, busy_o, done_o, err_o;
  logic [ADDR_W:0]   word_cnt_o;

  imem_boot_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RELEASE_DLY(RELEASE_DLY)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .s_valid_i(s_valid_i), .s_data_i(s_data_i),
    .s_last_i(s_last_i), .s_ready_o(s_ready_o), .im_web_o(im_web_o), .im_addrb_o(im_addrb_o),
    .im_dinb_o(im_dinb_o), .cpu_rst_o(cpu_rst_o), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .word_cnt_o(word_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; logic [31:0] data; } wr_t;

  int          total = 0;
  int          bad = 0;
  bit          mon_en = 1'b0;
  wr_t         exp_q[$];
  wr_t         mon_w;
  logic [31:0] img[$];
  bit          img_last;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Every write seen on port B must match the oldest write the model expects.
  always @(negedge clk) begin
    if (mon_en && im_web_o != 4'h0) begin
      check_val("web_val", im_web_o, 4'hF);
      check_val("wr_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        mon_w = exp_q.pop_front();
        check_val("wr_addr", im_addrb_o, mon_w.addr);
        check_val("wr_data", im_dinb_o, mon_w.data);
        check_val("wr_cnt", word_cnt_o, mon_w.addr + 1);
        $display("write addr=%0d data=0x%08h cnt=%0d", im_addrb_o, im_dinb_o, word_cnt_o);
      end
    end
  end

  // Outcome: 0 still loading, 1 reaches RUN, 2 reaches ERR.
  function automatic void model_load(output int n_acc, output int n_wr, output int outcome);
    int n;
    int d;
    logic [31:0] s;
    n = img.size();
    s = '0;
`ifdef BOOT_CHECKSUM_EN
    d = img_last ? n - 1 : n;
`else
    d = n;
`endif
    if (d > DEPTH || (d == DEPTH && (d == n ? !img_last : 1'b1))) begin
      n_acc = DEPTH; n_wr = DEPTH; outcome = 2;
    end else begin
      n_acc = n; n_wr = d;
      for (int i = 0; i < d; i++) s = s + img[i];
`ifdef BOOT_CHECKSUM_EN
      outcome = !img_last ? 0 : (s == img[n-1]) ? 1 : 2;
`else
      outcome = img_last ? 1 : 0;
`endif
    end
  endfunction

  task automatic check_reset_vals(input string p);
    check_val({p, "_ready"}, s_ready_o, 0);
    check_val({p, "_web"}, im_web_o, 0);
    check_val({p, "_addr"}, im_addrb_o, 0);
    check_val({p, "_din"}, im_dinb_o, 0);
    check_val({p, "_cpurst"}, cpu_rst_o, 1);
    check_val({p, "_busy"}, busy_o, 0);
    check_val({p, "_done"}, done_o, 0);
    check_val({p, "_err"}, err_o, 0);
    check_val({p, "_cnt"}, word_cnt_o, 0);
  endtask

  task automatic do_start(input bit with_beat);
    @(negedge clk);
    start_i = 1'b1; s_valid_i = with_beat; s_data_i = $urandom; s_last_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0; s_valid_i = 1'b0;
    check_val("start_ready", s_ready_o, 1);
    check_val("start_cnt", word_cnt_o, 0);
    check_val("start_cpurst", cpu_rst_o, 1);
    check_val("start_busy", busy_o, 1);
    check_val("start_done", done_o, 0);
    check_val("start_err", err_o, 0);
  endtask

  // Presents the first n_acc beats of img with random gaps; returns just after the final accepting edge.
  task automatic send_img(input int gap_pct, input int n_acc);
    int  i = 0;
    int  guard = 0;
    int  wr_idx = 0;
    bit  is_data;
    wr_t w;
    while (i < n_acc && guard < 400) begin
      @(negedge clk);
      guard++;
      start_i = s_ready_o && ($urandom_range(0, 9) == 0);
      if (int'($urandom_range(0, 99)) < gap_pct) begin
        s_valid_i = 1'b0; s_data_i = $urandom; s_last_i = $urandom_range(0, 1);
      end else begin
        s_valid_i = 1'b1; s_data_i = img[i]; s_last_i = img_last && (i == img.size() - 1);
      end
      if (s_valid_i && s_ready_o) begin
`ifdef BOOT_CHECKSUM_EN
        is_data = !s_last_i;
`else
        is_data = 1'b1;
`endif
        if (is_data) begin
          w.addr = wr_idx; w.data = img[i];
          exp_q.push_back(w);
          wr_idx++;
        end
        i++;
      end
    end
    @(posedge clk);
    #1;
    s_valid_i = 1'b0; s_last_i = 1'b0; start_i = 1'b0;
    check_val("accept_count", i, n_acc);
  endtask

  task automatic finish_check(input int outcome, input int n_wr);
    int k;
    if (outcome == 1) begin
      for (k = 1; k <= 40; k++) begin
        @(negedge clk);
        if (k == 1) begin
          check_val("drain_busy", busy_o, 1);
          check_val("drain_ready", s_ready_o, 0);
        end
        if (!cpu_rst_o) break;
      end
      check_val("release_lat", k - 1, RELEASE_DLY);
      check_val("run_done", done_o, 1);
      check_val("run_busy", busy_o, 0);
      check_val("run_err", err_o, 0);
    end else begin
      @(negedge clk);
      check_val("err_flag", err_o, 1);
      check_val("err_cpurst", cpu_rst_o, 1);
      check_val("err_ready", s_ready_o, 0);
      check_val("err_done", done_o, 0);
      check_val("err_busy", busy_o, 0);
    end
    #1;
    check_val("final_cnt", word_cnt_o, n_wr);
    check_val("wr_missing", exp_q.size(), 0);
  endtask

  task automatic run_load(input int gap_pct, input bit start_beat);
    int n_acc, n_wr, outcome;
    model_load(n_acc, n_wr, outcome);
    do_start(start_beat);
    send_img(gap_pct, n_acc);
    finish_check(outcome, n_wr);
    $display("load n=%0d last=%0d gap=%0d -> outcome=%0d words=%0d", img.size(), img_last, gap_pct, outcome, n_wr);
  endtask

  task automatic make_random_image(input int n);
    logic [31:0] s;
    img.delete();
    s = '0;
    for (int i = 0; i < n; i++) begin
      img.push_back($urandom);
      s = s + img[i];
    end
    img_last = 1'b1;
`ifdef BOOT_CHECKSUM_EN
    // Replace the final beat with a checksum that is right most of the time.
    s = s - img[n-1];
    img[n-1] = ($urandom_range(0, 3) == 0) ? s + 32'd1 : s;
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired @%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b0;
    #20;
    check_reset_vals("rst0");
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    check_val("idle_cpurst", cpu_rst_o, 1);
    check_val("idle_ready", s_ready_o, 0);

`ifdef BOOT_CHECKSUM_EN
    img = '{32'h1, 32'h2, 32'h3}; img_last = 1'b1;
    run_load(0, 1'b0);
    check_val("cs_ok_cnt", word_cnt_o, 2);
    img = '{32'h1, 32'h2, 32'h4}; img_last = 1'b1;
    run_load(0, 1'b0);
    check_val("cs_bad_err", err_o, 1);
`else
    img = '{32'h11, 32'h22, 32'h33, 32'h44}; img_last = 1'b1;
    run_load(0, 1'b0);
    check_val("basic_cnt", word_cnt_o, 4);
`endif

    img = '{32'hA0, 32'hA1, 32'hA2}; img_last = 1'b1;
    run_load(60, 1'b1);

    // Overflow: a full memory's worth of data beats with no last.
    img.delete();
    for (int i = 0; i < DEPTH; i++) img.push_back($urandom);
    img_last = 1'b0;
    run_load(20, 1'b0);

    // Reset in the middle of a load.
    img = '{32'h5, 32'h6, 32'h7, 32'h8, 32'h9}; img_last = 1'b1;
    do_start(1'b0);
    send_img(0, 2);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    @(negedge clk);
    rst = 1'b1;
    check_val("rst_mid_q", exp_q.size(), 0);
    img = '{32'hC0FFEE00, 32'h0BADF00D}; img_last = 1'b1;
    run_load(0, 1'b0);

    for (int t = 0; t < 12; t++) begin
      make_random_image($urandom_range(1, DEPTH + 4));
      run_load($urandom_range(0, 60), $urandom_range(0, 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
